// File: rtl/pipeline_exe.sv
// EXE stage: single-cycle ALU/MUL plus a restoring radix-2 divider that stalls IF/ID via busy_e_o.
// Registered outputs feed MEM; a divide occupies the stage for 34 cycles, flush squashes it at once.
module pipeline_exe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            valid_d_i,
   input  logic            flush_i,
   input  logic [3:0]      alu_op_d_i,
   input  logic [XLEN-1:0] src_a_d_i,
   input  logic [XLEN-1:0] src_b_d_i,
   input  logic [2:0]      dmem_type_d_i,
   input  logic [XLEN-1:0] extended_imm_d_i,
   input  logic [XLEN-1:0] pc_plus4_d_i,
   input  logic            reg_write_en_d_i,
   input  logic [4:0]      rd_idx_d_i,
   input  logic [3:0]      result_src_d_i,
   input  logic            instr_illegal_d_i,
   output logic [XLEN-1:0] alu_result_e_o,
   output logic [2:0]      dmem_type_e_o,
   output logic [XLEN-1:0] extended_imm_e_o,
   output logic [XLEN-1:0] pc_plus4_e_o,
   output logic            reg_write_en_e_o,
   output logic [4:0]      rd_idx_e_o,
   output logic [3:0]      result_src_e_o,
   output logic            instr_illegal_e_o,
   output logic            busy_e_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;

   logic [XLEN-1:0] alu_res, div_res, spec_res, result_d, a_abs, b_abs;
   logic [XLEN:0]   rem_sh, rem_diff;
   logic            is_div, is_rem, div_signed, div_zero, div_ovf, div_special, start_div, bubble;
   logic [4:0]      shamt;

   assign shamt       = src_b_d_i[4:0];
   assign is_div      = (alu_op_d_i[3:2] == 2'b11);
   assign is_rem      = alu_op_d_i[1];
   assign div_signed  = is_div && !alu_op_d_i[0];
   assign div_zero    = (src_b_d_i == '0);
   assign div_ovf     = div_signed && (src_a_d_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_d_i == '1);
   assign div_special = div_zero || div_ovf;
   assign start_div   = valid_d_i && is_div && !div_special;

   // Reset gating keeps every output at zero while resetn is low.
   assign busy_e_o = resetn && !flush_i &&
                     (((state_q == S_IDLE) && start_div) || (state_q == S_DIV));
   assign bubble   = !valid_d_i || flush_i || busy_e_o;

   assign a_abs = (div_signed && src_a_d_i[XLEN-1]) ? -src_a_d_i : src_a_d_i;
   assign b_abs = (div_signed && src_b_d_i[XLEN-1]) ? -src_b_d_i : src_b_d_i;

   // One restoring step: shift next dividend bit in, subtract if it fits.
   assign rem_sh   = {rem_q, quo_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, dvs_q};

   always_comb begin
      alu_res = '0;
      case (alu_op_d_i)
         4'd0:    alu_res = src_a_d_i + src_b_d_i;
         4'd1:    alu_res = src_a_d_i - src_b_d_i;
         4'd2:    alu_res = src_a_d_i << shamt;
         4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a_d_i) < $signed(src_b_d_i)};
         4'd4:    alu_res = {{(XLEN-1){1'b0}}, src_a_d_i < src_b_d_i};
         4'd5:    alu_res = src_a_d_i ^ src_b_d_i;
         4'd6:    alu_res = src_a_d_i >> shamt;
         4'd7:    alu_res = XLEN'($signed(src_a_d_i) >>> shamt);
         4'd8:    alu_res = src_a_d_i | src_b_d_i;
         4'd9:    alu_res = src_a_d_i & src_b_d_i;
         4'd10:   alu_res = src_a_d_i * src_b_d_i;
         4'd11:   alu_res = src_b_d_i;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      spec_res = '0;
      if (div_zero)
         spec_res = is_rem ? src_a_d_i : '1;
      else if (div_ovf)
         spec_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      div_res  = is_rem ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -quo_q : quo_q);
      result_d = '0;
      if (!bubble)
         result_d = !is_div ? alu_res : ((state_q == S_DONE) ? div_res : spec_res);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start_div) begin
               rem_d   = '0;
               quo_d   = a_abs;
               dvs_d   = b_abs;
               neg_q_d = div_signed && (src_a_d_i[XLEN-1] ^ src_b_d_i[XLEN-1]);
               neg_r_d = div_signed && src_a_d_i[XLEN-1];
               cnt_d   = 5'd31;
               state_d = S_DIV;
            end
            S_DIV: begin
               rem_d = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], !rem_diff[XLEN]};
               if (cnt_q == 5'd0) state_d = S_DONE;
               else               cnt_d   = cnt_q - 5'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q           <= S_IDLE;
         cnt_q             <= '0;
         rem_q             <= '0;
         quo_q             <= '0;
         dvs_q             <= '0;
         neg_q_q           <= 1'b0;
         neg_r_q           <= 1'b0;
         alu_result_e_o    <= '0;
         dmem_type_e_o     <= '0;
         extended_imm_e_o  <= '0;
         pc_plus4_e_o      <= '0;
         reg_write_en_e_o  <= 1'b0;
         rd_idx_e_o        <= '0;
         result_src_e_o    <= '0;
         instr_illegal_e_o <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         rem_q             <= rem_d;
         quo_q             <= quo_d;
         dvs_q             <= dvs_d;
         neg_q_q           <= neg_q_d;
         neg_r_q           <= neg_r_d;
         alu_result_e_o    <= result_d;
         dmem_type_e_o     <= bubble ? 3'b000 : dmem_type_d_i;
         extended_imm_e_o  <= bubble ? '0 : extended_imm_d_i;
         pc_plus4_e_o      <= bubble ? '0 : pc_plus4_d_i;
         reg_write_en_e_o  <= !bubble && reg_write_en_d_i;
         rd_idx_e_o        <= bubble ? 5'd0 : rd_idx_d_i;
         result_src_e_o    <= bubble ? 4'd0 : result_src_d_i;
         instr_illegal_e_o <= !bubble && instr_illegal_d_i;
      end
   end
endmodule

// File: doc/pipeline_exe.md
PIPELINE_EXE -- requirements
Module: pipeline_exe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; only 32 is supported.
REQ-002 SHALL have ports, one per line, name / direction / width / meaning:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid_d_i  in  1  ID/EX holds a real instruction.
- flush_i  in  1  synchronous squash of the EXE stage (branch/trap).
- alu_op_d_i  in  4  operation select; encoding in REQ-006.
- src_a_d_i, src_b_d_i  in  32 each  forwarded operands.
- dmem_type_d_i  in  3  load/store type; 3'b000 = no memory access.
- extended_imm_d_i, pc_plus4_d_i  in  32 each  passthrough.
- reg_write_en_d_i  in  1  passthrough.
- rd_idx_d_i  in  5  passthrough.
- result_src_d_i  in  4  passthrough.
- instr_illegal_d_i  in  1  passthrough.
- alu_result_e_o  out  32  registered result to the MEM stage.
- dmem_type_e_o, extended_imm_e_o, pc_plus4_e_o, reg_write_en_e_o, rd_idx_e_o, result_src_e_o, instr_illegal_e_o  out  widths as inputs  registered passthroughs to the MEM stage.
- busy_e_o  out  1  combinational stall request to IF/ID.
REQ-003 SHALL use a single clock, clk, and an asynchronous active-low reset, resetn.

Function
REQ-004 SHALL register all *_e_o outputs; a non-divide op SHALL appear on the outputs 1 cycle after it is presented with valid_d_i=1.
REQ-005 SHALL load a bubble when valid_d_i=0, flush_i=1, or busy_e_o=1: reg_write_en 0, dmem_type 000, result_src 0, instr_illegal 0, all other outputs 0.
REQ-006 SHALL support these alu_op encodings:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL (low 32 bits).
- 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- 11 PASSB (result = src_b).
REQ-007 SHALL use shift amount src_b[4:0], SHALL wrap all arithmetic modulo 2^32, and SHALL treat SLT/DIV/REM operands as two's complement.
REQ-008 SHALL implement division as a restoring radix-2 FSM with states IDLE, DIV and DONE, and a 5-bit iteration counter.
REQ-009 IDLE: a valid divide op with divisor != 0 and not signed overflow SHALL latch |operands| and the sign flags, load counter=31, go to DIV, and assert busy_e_o.
REQ-010 DIV: the FSM SHALL perform one quotient bit per cycle with busy_e_o=1; at counter==0 it SHALL go to DONE, otherwise decrement the counter.
REQ-011 DONE: the FSM SHALL deassert busy_e_o, apply sign correction (quotient negated if operand signs differ; remainder takes the dividend's sign), register the result with the passthrough fields currently held on the inputs, and return to IDLE.
REQ-012 A divide SHALL hold busy_e_o for 33 cycles, and its result SHALL reach the outputs 34 cycles after the op is first presented; upstream holds all *_d_i inputs stable while busy_e_o=1.
REQ-013 SHALL complete special divide cases in 1 cycle without busy:
- divisor 0: quotient 32'hFFFFFFFF, remainder = dividend.
- DIV/REM of 32'h80000000 by 32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
REQ-014 flush_i SHALL take priority over all other inputs: it SHALL force the FSM to IDLE, deassert busy_e_o the same cycle, load a bubble, and discard any in-flight divide.
REQ-015 SHALL issue no back-to-back divide restart; a second divide is accepted only in IDLE, i.e. on the cycle after DONE.
REQ-016 busy_e_o SHALL be a function of the FSM state, valid_d_i, flush_i, alu_op_d_i and the divide special-case detection only.

Reset
REQ-017 While resetn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and the counter SHALL be 0, independent of clk.
REQ-018 resetn asserted mid-divide SHALL abort the divide; after release the FSM SHALL be IDLE and busy_e_o SHALL be 0.

Verification
REQ-019 ADD 7+(-3), rd=5, reg_write_en=1 -> next cycle alu_result_e_o=4, rd_idx_e_o=5, reg_write_en_e_o=1.
REQ-020 SRA 32'h80000000 by 31; SLTU 1<2 -> 32'hFFFFFFFF; 1.
REQ-021 DIV -7/2 held -> busy 33 cycles with bubbles on the outputs, then alu_result_e_o=32'hFFFFFFFD; REM -7/2 gives 32'hFFFFFFFF.
REQ-022 DIVU 5/0 -> 1 cycle, result 32'hFFFFFFFF, no busy; DIV 32'h80000000/-1 -> 32'h80000000, no busy.
REQ-023 flush_i pulsed at DIV cycle 10 -> busy_e_o=0 the same cycle, bubble registered, FSM IDLE; the next ADD completes in 1 cycle.
REQ-024 resetn low for 1 cycle mid-divide -> all outputs 0 immediately; after release, MUL 3*-4 -> 32'hFFFFFFF4.
